// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and constants for the RSA job scheduler
package rsa_pkg;

  localparam int RSA_WIDTH = 128;
  localparam int RSA_ID_W  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INV_GO,
    S_INV_WAIT,
    S_EXP_GO,
    S_EXP_WAIT,
    S_RESP
  } rsa_seq_state_t;

endpackage

// File: rtl/rsa_rr_arb2.sv
// rtl/rsa_rr_arb2.sv - two-requester round-robin grant; pointer moves past the winner on accept
module rsa_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] ready,
  output logic       gnt_id
);

  logic rr_q, rr_d;

  always_comb begin
    gnt_id = valid[rr_q] ? rr_q : ~rr_q;
    ready  = 2'b00;
    if (en && valid[gnt_id]) ready[gnt_id] = 1'b1;
    rr_d = rr_q;
    if (|ready) rr_d = ~gnt_id;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/rsa_job_sched.sv
// rtl/rsa_job_sched.sv - job sequencer for a shared RSA core with inverter-result key cache
// Optional per-phase watchdog enabled by RSA_SEQ_WATCHDOG_EN.
module rsa_job_sched
  import rsa_pkg::*;
#(
  parameter int WIDTH       = RSA_WIDTH,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_p,
  input  logic [2*WIDTH-1:0]   req_q,
  input  logic [1:0]           req_mode,
  input  logic [4*WIDTH-1:0]   req_msg,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_msg,
  output logic                 rsp_err,
  output logic [WIDTH-1:0]     core_p,
  output logic [WIDTH-1:0]     core_q,
  output logic                 core_encrypt_decrypt,
  output logic [2*WIDTH-1:0]   core_msg_in,
  output logic                 core_reset_inverter,
  output logic                 core_reset_mod_exp,
  input  logic                 core_inverter_finish,
  input  logic                 core_mod_exp_finish,
  input  logic [2*WIDTH-1:0]   core_msg_out
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("rsa_job_sched: TIMEOUT_CYC must be at least 2");
  end

  rsa_seq_state_t state_q, state_d;
  logic accept, gnt_id, hit;
  logic latch_job, load_key, cap_rsp, wd_hit, wd_fire;
  logic [WIDTH-1:0]    sel_p, sel_q;
  logic [2*WIDTH-1:0]  sel_msg;
  logic [WIDTH-1:0]    core_p_q, core_q_q, key_p_q, key_q_q;
  logic                core_mode_q, key_vld_q;
  logic [2*WIDTH-1:0]  core_msg_q, rsp_msg_q;
  logic [RSA_ID_W-1:0] id_q;

  // Grants are only offered in IDLE and never while reset is held.
  rsa_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (state_q == S_IDLE && !reset),
    .valid  (req_valid),
    .ready  (req_ready),
    .gnt_id (gnt_id)
  );

  assign accept  = |req_ready;
  assign sel_p   = gnt_id ? req_p[2*WIDTH-1:WIDTH]     : req_p[WIDTH-1:0];
  assign sel_q   = gnt_id ? req_q[2*WIDTH-1:WIDTH]     : req_q[WIDTH-1:0];
  assign sel_msg = gnt_id ? req_msg[4*WIDTH-1:2*WIDTH] : req_msg[2*WIDTH-1:0];
  assign hit     = key_vld_q && (sel_p == key_p_q) && (sel_q == key_q_q);

  always_comb begin
    state_d   = state_q;
    latch_job = 1'b0;
    load_key  = 1'b0;
    cap_rsp   = 1'b0;
    wd_fire   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        latch_job = 1'b1;
        state_d   = hit ? S_EXP_GO : S_INV_GO;
      end
      S_INV_GO: state_d = S_INV_WAIT;
      S_INV_WAIT: begin
        if (core_inverter_finish) begin
          load_key = 1'b1;
          state_d  = S_EXP_GO;
        end else if (wd_hit) begin
          wd_fire = 1'b1;
          state_d = S_RESP;
        end
      end
      S_EXP_GO: state_d = S_EXP_WAIT;
      S_EXP_WAIT: begin
        if (core_mod_exp_finish) begin
          cap_rsp = 1'b1;
          state_d = S_RESP;
        end else if (wd_hit) begin
          wd_fire = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_p_q    <= '0;
      core_q_q    <= '0;
      core_mode_q <= 1'b0;
      core_msg_q  <= '0;
      id_q        <= '0;
      key_vld_q   <= 1'b0;
      key_p_q     <= '0;
      key_q_q     <= '0;
      rsp_msg_q   <= '0;
    end else begin
      if (latch_job) begin
        core_p_q    <= sel_p;
        core_q_q    <= sel_q;
        core_mode_q <= req_mode[gnt_id];
        core_msg_q  <= sel_msg;
        id_q        <= gnt_id;
      end
      if (load_key) begin
        key_vld_q <= 1'b1;
        key_p_q   <= core_p_q;
        key_q_q   <= core_q_q;
      end
      // A timed-out job leaves the core state unknown, so the cached key is dropped.
      if (wd_fire) begin
        key_vld_q <= 1'b0;
        rsp_msg_q <= '0;
      end
      if (cap_rsp) rsp_msg_q <= core_msg_out;
    end
  end

`ifdef RSA_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [WD_W-1:0] wd_q;
  logic            rsp_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q      <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_q == S_INV_GO || state_q == S_EXP_GO)        wd_q <= '0;
      else if (state_q == S_INV_WAIT || state_q == S_EXP_WAIT) wd_q <= wd_q + WD_W'(1);
      if (cap_rsp)      rsp_err_q <= 1'b0;
      else if (wd_fire) rsp_err_q <= 1'b1;
    end
  end

  assign wd_hit  = (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign rsp_err = rsp_err_q;
`else
  assign wd_hit  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign rsp_valid            = (state_q == S_RESP);
  assign rsp_id               = id_q;
  assign rsp_msg              = rsp_msg_q;
  assign core_p               = core_p_q;
  assign core_q               = core_q_q;
  assign core_encrypt_decrypt = core_mode_q;
  assign core_msg_in          = core_msg_q;
  assign core_reset_inverter  = (state_q == S_INV_GO);
  assign core_reset_mod_exp   = (state_q == S_EXP_GO);

endmodule

// File: tb/tb_rsa_job_sched.sv
// tb/tb_rsa_job_sched.sv - randomized self-checking bench with stub core and job-level reference model
module tb_rsa_job_sched;

  localparam int W  = 128;
  localparam int TO = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_ready;
  logic            rsp_valid, rsp_id, rsp_err;
  logic            rsp_ready = 1'b0;
  logic [2*W-1:0]  rsp_msg;
  logic [W-1:0]    core_p, core_q;
  logic            core_encrypt_decrypt, core_reset_inverter, core_reset_mod_exp;
  logic [2*W-1:0]  core_msg_in;
  logic            inv_fin = 1'b0, exp_fin = 1'b0;
  logic [2*W-1:0]  core_msg_out = '0;

  logic [W-1:0]    jp [2], jq [2];
  logic            jmode [2];
  logic [2*W-1:0]  jmsg [2];

  int n_checks = 0, n_fail = 0, cyc = 0;

  // stub core bookkeeping (written only by the stub process)
  int inv_pulses = 0, exp_pulses = 0, inv_go_cyc = 0, exp_go_cyc = 0, inv_fin_cyc = 0, exp_fin_cyc = 0;
  int inv_cd = -1, exp_cd = -1;
  logic [W-1:0]   cap_p, cap_q;
  logic           cap_mode;
  logic [2*W-1:0] cap_msg;
  int lat_inv = 2, lat_exp = 2;
  bit stub_hang = 0;

  // reference model state
  int m_rr = 0;
  bit m_kv = 0;
  logic [W-1:0]   m_kp, m_kq;
  logic [2*W-1:0] last_rsp;

  rsa_job_sched #(.WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_p({jp[1], jp[0]}), .req_q({jq[1], jq[0]}),
    .req_mode({jmode[1], jmode[0]}), .req_msg({jmsg[1], jmsg[0]}),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_msg(rsp_msg), .rsp_err(rsp_err),
    .core_p(core_p), .core_q(core_q), .core_encrypt_decrypt(core_encrypt_decrypt),
    .core_msg_in(core_msg_in), .core_reset_inverter(core_reset_inverter),
    .core_reset_mod_exp(core_reset_mod_exp), .core_inverter_finish(inv_fin),
    .core_mod_exp_finish(exp_fin), .core_msg_out(core_msg_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [271:0] got, input logic [271:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stub core: an involution (msg ^ {p,q}) so decrypting a result returns the original.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        inv_fin = 0; exp_fin = 0; inv_cd = -1; exp_cd = -1; core_msg_out = '0;
      end else begin
        if (core_reset_inverter) begin
          inv_pulses++; inv_go_cyc = cyc; inv_fin = 0;
          inv_cd = stub_hang ? -1 : lat_inv;
        end else if (inv_cd == 0) begin
          inv_fin = 1; inv_fin_cyc = cyc; inv_cd = -1;
        end else if (inv_cd > 0) inv_cd--;
        if (core_reset_mod_exp) begin
          exp_pulses++; exp_go_cyc = cyc; exp_fin = 0;
          cap_p = core_p; cap_q = core_q; cap_mode = core_encrypt_decrypt; cap_msg = core_msg_in;
          exp_cd = stub_hang ? -1 : lat_exp;
        end else if (exp_cd == 0) begin
          exp_fin = 1; exp_fin_cyc = cyc; exp_cd = -1;
          core_msg_out = core_msg_in ^ {core_p, core_q};
        end else if (exp_cd > 0) exp_cd--;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp"}, {req_ready, rsp_valid, rsp_id, rsp_err, rsp_msg}, '0);
    chk({tag, "_key"}, {core_p, core_q}, '0);
    chk({tag, "_core"}, {core_encrypt_decrypt, core_reset_inverter, core_reset_mod_exp, core_msg_in}, '0);
  endtask

  task automatic run_job(input logic [1:0] vmask, input bit keep, input int stall);
    int g, w, t, inv0, exp0, rise;
    bit hit;
    logic [2*W-1:0] exp_out;
    g = vmask[m_rr] ? m_rr : 1 - m_rr;
    req_valid = vmask;
    #1;
    w = 0;
    while (req_ready == 2'b00 && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) begin chk("accept_wait", 0, 1); req_valid = 2'b00; return; end
    chk("grant", req_ready, 2'b01 << g);
    t = cyc; inv0 = inv_pulses; exp0 = exp_pulses;
    hit = m_kv && jp[g] == m_kp && jq[g] == m_kq;
    exp_out = stub_hang ? '0 : (jmsg[g] ^ {jp[g], jq[g]});
    m_rr = 1 - g;
    @(negedge clk);
    if (!keep) req_valid = 2'b00;
    w = 0;
    while (!rsp_valid && w < 300) begin @(negedge clk); w++; end
    if (w >= 300) begin chk("rsp_wait", 0, 1); return; end
    rise = cyc; last_rsp = rsp_msg;
    chk("rsp_id", rsp_id, g);
    chk("rsp_msg", rsp_msg, exp_out);
    if (stub_hang) begin
      chk("wd_err", rsp_err, 1);
      chk("wd_latency", rise, inv_go_cyc + 1 + TO);
      chk("wd_inv", inv_pulses - inv0, 1);
      m_kv = 0;
    end else begin
      chk("inv_pulses", inv_pulses - inv0, hit ? 0 : 1);
      chk("exp_pulses", exp_pulses - exp0, 1);
      if (hit) chk("exp_go_hit", exp_go_cyc, t + 1);
      else begin
        chk("inv_go", inv_go_cyc, t + 1);
        chk("exp_go_miss", exp_go_cyc, inv_fin_cyc + 1);
      end
      chk("rsp_latency", rise, exp_fin_cyc + 1);
      chk("rsp_err", rsp_err, 0);
      chk("core_in", {cap_mode, cap_p, cap_q}, {jmode[g], jp[g], jq[g]});
      chk("core_msg", cap_msg, jmsg[g]);
      m_kv = 1; m_kp = jp[g]; m_kq = jq[g];
    end
    repeat (stall) begin
      @(negedge clk);
      chk("stall", {rsp_valid, rsp_id, req_ready, rsp_msg}, {1'b1, g[0], 2'b00, exp_out});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", rsp_valid, 0);
  endtask

  initial begin
    logic [W-1:0]   pool_p [3], pool_q [3];
    logic [2*W-1:0] orig;
    int k, w, e0;
    for (int i = 0; i < 3; i++)
      for (int b = 0; b < 4; b++) begin
        pool_p[i][b*32 +: 32] = $urandom;
        pool_q[i][b*32 +: 32] = $urandom;
      end
    for (int r = 0; r < 2; r++) begin jp[r] = '0; jq[r] = '0; jmode[r] = 0; jmsg[r] = '0; end

    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    req_valid = 2'b00;
    reset = 1'b0;
    @(negedge clk);

    // first job and the cached-key decrypt of its result
    jp[0] = 128'd113680897410347; jq[0] = 128'd7999808077935876437321;
    jmode[0] = 0; jmsg[0] = 256'hb37b2857e7e149; orig = jmsg[0];
    lat_inv = 3; lat_exp = 5;
    run_job(2'b01, 0, 0);
    jmode[0] = 1; jmsg[0] = last_rsp;
    run_job(2'b01, 0, 10);
    chk("roundtrip", last_rsp, orig);

    // reset while waiting on the exponentiator
    lat_exp = 20; jmsg[0] = {8{32'h5a5a_1234}};
    e0 = exp_pulses;
    req_valid = 2'b01;
    #1;
    w = 0;
    while (req_ready == 2'b00 && w < 50) begin @(negedge clk); w++; end
    chk("rst_job_accept", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    w = 0;
    while (exp_pulses == e0 && w < 50) begin @(negedge clk); w++; end
    chk("rst_job_cached", exp_pulses - e0, 1);
    @(negedge clk); @(negedge clk);
    req_valid = 2'b11;
    reset = 1'b1;
    #1;
    check_reset_outputs("midjob_reset");
    @(negedge clk); @(negedge clk);
    req_valid = 2'b00; reset = 1'b0;
    m_kv = 0; m_rr = 0; lat_exp = 4;
    @(negedge clk);

    // both requesters continuously valid, same key as before the reset
    jp[1] = jp[0]; jq[1] = jq[0]; jmode[1] = 0; jmsg[1] = {8{32'hc0de_0001}};
    for (int i = 0; i < 4; i++) run_job(2'b11, i < 3, 1);

    for (int i = 0; i < 16; i++) begin
      for (int r = 0; r < 2; r++) begin
        k = $urandom_range(0, 2);
        jp[r] = pool_p[k]; jq[r] = pool_q[k];
        jmode[r] = 1'($urandom_range(0, 1));
        for (int b = 0; b < 8; b++) jmsg[r][b*32 +: 32] = $urandom;
      end
      lat_inv = $urandom_range(0, 12);
      lat_exp = $urandom_range(0, 12);
      run_job(2'($urandom_range(1, 3)), 0, $urandom_range(0, 3));
    end

`ifdef RSA_SEQ_WATCHDOG_EN
    for (int b = 0; b < 4; b++) jp[0][b*32 +: 32] = $urandom;
    stub_hang = 1;
    run_job(2'b01, 0, 2);
    stub_hang = 0;
    run_job(2'b01, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_job_sched.md
# rsa_job_sched

Round-robin job scheduler and sequencer for one shared `control` RSA core (modular inverter plus modular exponentiator). Two requesters submit (p, q, mode, message) jobs over valid/ready. The block grants one job at a time and drives the core's `reset_inverter` / `reset_mod_exp` pulses, waiting on each finish flag. It skips the inverter phase when the key (p, q) is unchanged, then returns the core output on a response handshake tagged with the requester id.

## Interface
- `WIDTH`, 128: width of p and q; messages are 2*WIDTH.
- `TIMEOUT_CYC`, 65536: watchdog limit per core phase (used only with the macro).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req_valid` in 2: per-requester job valid.
- `req_ready` out 2: per-requester accept; at most one bit high.
- `req_p`, `req_q` in 2*WIDTH: requester i at bits [i*WIDTH +: WIDTH].
- `req_mode` in 2: encrypt_decrypt per requester.
- `req_msg` in 4*WIDTH: requester i at [i*2*WIDTH +: 2*WIDTH].
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_id` out 1: requester that owns the result.
- `rsp_msg` out 2*WIDTH: core result.
- `rsp_err` out 1: watchdog fired; `rsp_msg` is zero.
- `core_p`, `core_q` out WIDTH: registered key to core.
- `core_encrypt_decrypt` out 1: registered mode.
- `core_msg_in` out 2*WIDTH: registered message.
- `core_reset_inverter` out 1: one-cycle start pulse.
- `core_reset_mod_exp` out 1: one-cycle start pulse.
- `core_inverter_finish` in 1: level, high when the inverter is done.
- `core_mod_exp_finish` in 1: level, high when the exponentiator is done.
- `core_msg_out` in 2*WIDTH: core result, valid while `core_mod_exp_finish` is high.

## Operation
- States: IDLE, INV_GO, INV_WAIT, EXP_GO, EXP_WAIT, RESP.
- IDLE: the round-robin pointer `rr` picks a requester; requester `rr` wins a tie. `req_ready[g]` is asserted combinationally for the granted valid requester. On the handshake:
  - latch p, q, mode, msg and id;
  - set `rr` to ~g.
- Key cache: `key_vld`, `key_p`, `key_q`.
  - Accepted job with `key_vld` set and p == key_p and q == key_q: go to EXP_GO.
  - Otherwise: go to INV_GO.
- INV_GO: `core_reset_inverter`=1 for exactly this cycle; go to INV_WAIT. Finish is not sampled in the GO cycle.
- INV_WAIT: on `core_inverter_finish`=1, load key_p/key_q, set `key_vld`, go to EXP_GO.
- EXP_GO: `core_reset_mod_exp`=1 for one cycle; go to EXP_WAIT.
- EXP_WAIT: on `core_mod_exp_finish`=1, capture `core_msg_out` into `rsp_msg`, set `rsp_err`=0, go to RESP.
- RESP: `rsp_valid`=1, all req_ready=0. On `rsp_ready`=1, return to IDLE.
- Core inputs (p, q, mode, msg) are held stable from INV_GO or EXP_GO through the finish.
- Mode is not part of the cache key. An encrypt followed by a decrypt with the same key reuses the inverter result.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_msg=0, rsp_err=0;
  - core_* outputs all 0;
  - key_vld=0, rr=0, state IDLE.
- Handshake cycle is T. INV_GO is at T+1; the inverter finish is sampled from T+2.
- After the inverter finish at cycle F, EXP_GO is at F+1.
- After the exponentiator finish at cycle E, rsp_valid is high at E+1.
- Cached key: EXP_GO at T+1.
- A new job can be accepted at the earliest one cycle after the `rsp_ready` handshake, once back in IDLE. No overlap between jobs.
- `rsp_msg`/`rsp_id` are stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-job: everything returns to reset values immediately; the cache is invalidated; the in-flight job is dropped. The requester must resubmit.

## Configuration
- `RSA_SEQ_WATCHDOG_EN` defined:
  - A counter runs in INV_WAIT and EXP_WAIT and clears on entry to each.
  - Reaching TIMEOUT_CYC: go to RESP with rsp_err=1, rsp_msg=0, key_vld=0.
- Undefined: no counter; the WAIT states wait indefinitely; rsp_err is tied to 0.

## Structure
- Package `rsa_pkg`: state enum `rsa_seq_state_t`, default WIDTH, id width constant.
- Sub-module `rsa_rr_arb2`: two-requester round-robin grant with pointer update on accept.
- FSM, key cache and watchdog live in the top module.

## Test plan
- Single job, req0: p=113680897410347, q=7999808077935876437321, mode 0, msg 0xb37b2857e7e149 → one inverter pulse, then one mod_exp pulse; response id 0 matches the stub core's output.
- Same key resubmitted, mode 1, msg = previous result → no inverter pulse; EXP_GO one cycle after accept; result returns the original message on the real core.
- Both req_valid high continuously, 4 jobs, rr=0 after reset → grant order 0,1,0,1.
- rsp_ready held low 10 cycles → rsp_valid, rsp_msg and rsp_id stay stable; no req_ready asserted.
- Reset asserted in EXP_WAIT → all outputs 0 in the same cycle; the next job with the same key runs the inverter phase.
- With `RSA_SEQ_WATCHDOG_EN`, TIMEOUT_CYC=32, stub never finishes → rsp_err=1 32 cycles after INV_GO+1; the next job runs the inverter.
